// File: rtl/fir_decim_output_stage_if.sv
// rtl/fir_decim_output_stage_if.sv - sample input and FIFO output handshake bundle
interface fir_decim_output_stage_if #(
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 16
);
  logic                    valid_in;
  logic [INPUT_WIDTH-1:0]  din;
  logic                    phase_sync;
  logic                    dout_valid;
  logic                    dout_ready;
  logic [OUTPUT_WIDTH-1:0] dout;

  modport master (
    output valid_in, din, phase_sync, dout_ready,
    input  dout_valid, dout
  );

  modport slave (
    input  valid_in, din, phase_sync, dout_ready,
    output dout_valid, dout
  );
endinterface

// File: rtl/fir_decim_output_stage.sv
// rtl/fir_decim_output_stage.sv - decimate, round, saturate and queue FIR output samples
module fir_decim_output_stage #(
  parameter int INPUT_WIDTH  = 26,
  parameter int OUTPUT_WIDTH = 16,
  parameter int SHIFT        = 10,
  parameter int DECIM        = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  fir_decim_output_stage_if.slave bus,
  input  logic                    flag_clear_i,
  output logic                    sat_flag_o,
  output logic                    drop_flag_o
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_PH = CW'(DECIM - 1);
  localparam logic [CW-1:0] SYNC_PH = CW'(1 % DECIM);
  localparam logic signed [INPUT_WIDTH:0] RND = ((INPUT_WIDTH+1)'(1) << SHIFT) >> 1;
  localparam logic signed [INPUT_WIDTH:0] OMAX =
    {{(INPUT_WIDTH-OUTPUT_WIDTH+2){1'b0}}, {(OUTPUT_WIDTH-1){1'b1}}};
  localparam logic signed [INPUT_WIDTH:0] OMIN =
    {{(INPUT_WIDTH-OUTPUT_WIDTH+2){1'b1}}, {(OUTPUT_WIDTH-1){1'b0}}};

  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    pipe_v_q, pipe_v_d;
  logic [OUTPUT_WIDTH-1:0] pipe_data_q, pipe_data_d;
  logic                    sat_q, sat_d, drop_q, drop_d;
  logic [AW:0]             wptr_q, wptr_d, rptr_q, rptr_d;
  logic [OUTPUT_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic signed [INPUT_WIDTH:0] sum, rnd;
  logic                    keep, sat_hi, sat_lo;
  logic                    empty, full, pop, push;

  // Round in one extra bit so the half-LSB offset can never wrap.
  always_comb begin
    sum    = $signed({bus.din[INPUT_WIDTH-1], bus.din}) + RND;
    rnd    = sum >>> SHIFT;
    sat_hi = rnd > OMAX;
    sat_lo = rnd < OMIN;
    keep   = bus.valid_in & ((cnt_q == '0) | bus.phase_sync);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (bus.valid_in) begin
      if (bus.phase_sync)      cnt_d = SYNC_PH;
      else if (cnt_q == LAST_PH) cnt_d = '0;
      else                     cnt_d = cnt_q + CW'(1);
    end
    pipe_v_d    = keep;
    pipe_data_d = pipe_data_q;
    if (keep) begin
      if (sat_hi)      pipe_data_d = OMAX[OUTPUT_WIDTH-1:0];
      else if (sat_lo) pipe_data_d = OMIN[OUTPUT_WIDTH-1:0];
      else             pipe_data_d = rnd[OUTPUT_WIDTH-1:0];
    end
  end

  // Full means same slot index with opposite wrap bit.
  always_comb begin
    empty  = (wptr_q == rptr_q);
    full   = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    pop    = ~empty & bus.dout_ready;
    push   = pipe_v_q & (~full | pop);
    wptr_d = wptr_q + (AW+1)'(push);
    rptr_d = rptr_q + (AW+1)'(pop);
    sat_d  = (keep & (sat_hi | sat_lo)) | (sat_q & ~flag_clear_i);
    drop_d = (pipe_v_q & ~push) | (drop_q & ~flag_clear_i);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q       <= '0;
      pipe_v_q    <= 1'b0;
      pipe_data_q <= '0;
      sat_q       <= 1'b0;
      drop_q      <= 1'b0;
      wptr_q      <= '0;
      rptr_q      <= '0;
    end else begin
      cnt_q       <= cnt_d;
      pipe_v_q    <= pipe_v_d;
      pipe_data_q <= pipe_data_d;
      sat_q       <= sat_d;
      drop_q      <= drop_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= pipe_data_q;
  end

  assign bus.dout_valid = ~empty;
  assign bus.dout       = empty ? '0 : mem_q[rptr_q[AW-1:0]];
  assign sat_flag_o     = sat_q;
  assign drop_flag_o    = drop_q;
endmodule
